// File: rtl/fetch_imem.sv
// fetch_imem: instruction memory with an in-order, pipelined fetch port and an independent program-load write port.
// Define IMEM_BOOT_PRELOAD_EN to load a 4-word boot stub at reset; otherwise reset clears all words to zero.
module fetch_imem #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned FETCH_WORDS = 1,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [31:0]               req_addr_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [32*FETCH_WORDS-1:0] rsp_data_o,
  output logic                      rsp_err_o,
  input  logic                      wr_en_i,
  input  logic [31:0]               wr_addr_i,
  input  logic [31:0]               wr_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 32 * FETCH_WORDS;
  localparam int unsigned NB = LATENCY + 1;
  localparam int unsigned PW = $clog2(NB);
  localparam int unsigned CW = $clog2(NB + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NB - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage and program-load write port
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_idx;
  logic          wr_ok;

  assign wr_idx = wr_addr_i[AW+1:2];
  assign wr_ok  = wr_en_i && (wr_addr_i[1:0] == 2'b00) && (wr_addr_i[31:AW+2] == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef IMEM_BOOT_PRELOAD_EN
      mem_q[0] <= 32'h000F50B7;
      mem_q[1] <= 32'h00002117;
      mem_q[2] <= 32'hFFF08193;
      mem_q[3] <= 32'h00004237;
`endif
    end else if (wr_ok) begin
      mem_q[wr_idx] <= wr_data_i;
    end
  end

  // Read sees pre-write contents, so a same-edge write and fetch return old data
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic [DW-1:0] rd_data;

  assign rd_idx = req_addr_i[AW+1:2];
  assign rd_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:AW+2] != '0);

  always_comb begin
    rd_data = '0;
    if (!rd_err) begin
      for (int unsigned k = 0; k < FETCH_WORDS; k++) begin
        rd_data[32*k +: 32] = mem_q[rd_idx + AW'(k)];
      end
    end
  end

  // Response buffer: each entry counts down to maturity, giving the fixed latency
  // while entries stay in acceptance order; the head is the only one presented.
  logic [DW-1:0] buf_data_q [NB];
  logic          buf_err_q  [NB];
  logic [1:0]    buf_wait_q [NB];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign req_ready_o = !rst_i && (cnt_q < CW'(NB));
  assign rsp_valid_o = (cnt_q != '0) && (buf_wait_q[rd_ptr_q] == 2'd0);
  assign rsp_data_o  = rsp_valid_o ? buf_data_q[rd_ptr_q] : '0;
  assign rsp_err_o   = rsp_valid_o ? buf_err_q[rd_ptr_q] : 1'b0;

  assign push = req_valid_i && req_ready_o;
  assign pop  = rsp_valid_o && rsp_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        buf_data_q[i] <= '0;
        buf_err_q[i]  <= 1'b0;
        buf_wait_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int unsigned i = 0; i < NB; i++) begin
        if (buf_wait_q[i] != 2'd0) begin
          buf_wait_q[i] <= buf_wait_q[i] - 2'd1;
        end
      end
      if (push) begin
        buf_data_q[wr_ptr_q] <= rd_data;
        buf_err_q[wr_ptr_q]  <= rd_err;
        buf_wait_q[wr_ptr_q] <= 2'(LATENCY - 1);
      end
    end
  end

endmodule
